// File: rtl/pipeline_divider_hs.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_divider_hs
//  Purpose  : Fully pipelined restoring integer divider with valid/ready
//             flow control, optional two's-complement operation and a
//             configurable number of quotient bits resolved per stage.
//             One dividend/divisor pair per cycle; results return in order
//             after N_ITER+2 cycles when the output is not stalled.
//  Ports    : clk_i, rst_i (async, active high)
//             valid_i / ready_o / dividend_i / divisor_i  - input side
//             valid_o / ready_i / quotient_o / remainder_o - output side
//             dbz_o - divide-by-zero flag, present only when the macro
//                     PIPE_DIV_DBZ_EN is defined
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_divider_hs #(
  parameter int DIVIDEND_WIDTH = 8,
  parameter int DIVISOR_WIDTH  = 8,
  parameter int BITS_PER_STAGE = 1,
  parameter int SIGNED         = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [DIVIDEND_WIDTH-1:0] dividend_i,
  input  logic [DIVISOR_WIDTH-1:0]  divisor_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [DIVIDEND_WIDTH-1:0] quotient_o,
  output logic [DIVISOR_WIDTH-1:0]  remainder_o
`ifdef PIPE_DIV_DBZ_EN
  ,
  output logic                      dbz_o
`endif
);

  localparam int DW        = DIVIDEND_WIDTH;
  localparam int DVW       = DIVISOR_WIDTH;
  localparam int BPS       = BITS_PER_STAGE;
  localparam int N_ITER    = (DW + BPS - 1) / BPS;
  localparam int LAST_BITS = DW - BPS * (N_ITER - 1);
  localparam int PW        = ((DW > DVW) ? DW : DVW) + 1;

  // Whole pipeline moves together; it only freezes when a finished result
  // is waiting on the consumer.
  logic advance;
  assign ready_o = !valid_o || ready_i;
  assign advance = ready_o;

  // Index 0 holds the registered operands, index k the state after k
  // iteration stages.
  logic [N_ITER:0]  stg_vld;
  logic [N_ITER:0]  stg_qneg;
  logic [N_ITER:0]  stg_rneg;
  logic [PW-1:0]    stg_rem [N_ITER+1];
  logic [DW-1:0]    stg_dq  [N_ITER+1];
  logic [DVW-1:0]   stg_dvs [N_ITER];
  logic [PW-1:0]    nxt_rem [N_ITER];
  logic [DW-1:0]    nxt_dq  [N_ITER];

  // ---------------------------------------------------------------- stage 0
  logic           dvs_zero;
  logic           dvd_neg;
  logic           dvs_neg;
  logic [DW-1:0]  dvd_mag;
  logic [DVW-1:0] dvs_mag;

  always_comb begin
    dvs_zero = (divisor_i == '0);
    dvd_neg  = (SIGNED != 0) && dividend_i[DW-1];
    dvs_neg  = (SIGNED != 0) && divisor_i[DVW-1];
    // A zero divisor divides the raw dividend bits unsigned: the restoring
    // loop then yields an all-ones quotient and leaves the dividend itself
    // as remainder, which is exactly the divide-by-zero result.
    dvd_mag  = (dvd_neg && !dvs_zero) ? -dividend_i : dividend_i;
    dvs_mag  = dvs_neg ? -divisor_i : divisor_i;
  end

  // --------------------------------------------------------- iteration step
  // dq starts as the dividend magnitude; each step shifts its MSB into the
  // partial remainder and a quotient bit into its LSB.
  function automatic logic [PW+DW-1:0] div_step(
    input logic [PW-1:0]  rem_in,
    input logic [DW-1:0]  dq_in,
    input logic [DVW-1:0] dvs,
    input int             nbits
  );
    logic [PW-1:0] rem;
    logic [DW-1:0] dq;
    rem = rem_in;
    dq  = dq_in;
    for (int i = 0; i < BPS; i++) begin
      if (i < nbits) begin
        rem = {rem[PW-2:0], dq[DW-1]};
        dq  = {dq[DW-2:0], 1'b0};
        if (rem >= PW'(dvs)) begin
          rem   = rem - PW'(dvs);
          dq[0] = 1'b1;
        end
      end
    end
    return {rem, dq};
  endfunction

  always_comb begin
    for (int k = 0; k < N_ITER; k++) begin
      {nxt_rem[k], nxt_dq[k]} = div_step(stg_rem[k], stg_dq[k], stg_dvs[k],
                                         (k == N_ITER - 1) ? LAST_BITS : BPS);
    end
  end

  // ------------------------------------------------------------ data path
  always_ff @(posedge clk_i) begin
    if (advance) begin
      stg_rem[0] <= '0;
      stg_dq[0]  <= dvd_mag;
      stg_dvs[0] <= dvs_mag;
      stg_qneg   <= {stg_qneg[N_ITER-1:0], (dvd_neg ^ dvs_neg) && !dvs_zero};
      stg_rneg   <= {stg_rneg[N_ITER-1:0], dvd_neg && !dvs_zero};
      for (int k = 0; k < N_ITER; k++) begin
        stg_rem[k+1] <= nxt_rem[k];
        stg_dq[k+1]  <= nxt_dq[k];
      end
      for (int k = 0; k < N_ITER - 1; k++) begin
        stg_dvs[k+1] <= stg_dvs[k];
      end
    end
  end

  // ------------------------------------------------------ sign fix / output
  logic [DW-1:0]  quo_fix;
  logic [DVW-1:0] rem_fix;
  logic           rem_unused;

  always_comb begin
    quo_fix = stg_qneg[N_ITER] ? -stg_dq[N_ITER] : stg_dq[N_ITER];
    rem_fix = stg_rneg[N_ITER] ? -stg_rem[N_ITER][DVW-1:0]
                               : stg_rem[N_ITER][DVW-1:0];
  end

  // Final partial remainder is always below the divisor magnitude (or the
  // dividend for a zero divisor), so its upper bits carry no information.
  assign rem_unused = ^stg_rem[N_ITER][PW-1:DVW];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stg_vld     <= '0;
      valid_o     <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else if (advance) begin
      stg_vld <= {stg_vld[N_ITER-1:0], valid_i};
      valid_o <= stg_vld[N_ITER];
      if (stg_vld[N_ITER]) begin
        quotient_o  <= quo_fix;
        remainder_o <= rem_fix;
      end
    end
  end

`ifdef PIPE_DIV_DBZ_EN
  logic [N_ITER:0] stg_dbz;

  always_ff @(posedge clk_i) begin
    if (advance) begin
      stg_dbz <= {stg_dbz[N_ITER-1:0], dvs_zero};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dbz_o <= 1'b0;
    end else if (advance) begin
      dbz_o <= stg_vld[N_ITER] && stg_dbz[N_ITER];
    end
  end
`endif

endmodule
`default_nettype wire
